// File: rtl/cs_pkg.sv
// Shared constants and FSM encoding for the context-switch controller.
package cs_pkg;

  localparam int CS_NPROC = 4;
  localparam int CS_PIDW  = 2;

  typedef enum logic [2:0] {
    S_EMPTY   = 3'd0,
    S_RUN     = 3'd1,
    S_SAVE    = 3'd2,
    S_SELECT  = 3'd3,
    S_RESTORE = 3'd4
  } cs_state_t;

endpackage

// File: rtl/context_switch_ctrl_if.sv
// Bus between the PC/OS side (master) and the context-switch controller (slave).
interface context_switch_ctrl_if
  import cs_pkg::*;
#(
  parameter int PIDW = CS_PIDW
);
  logic            ContextChangeBack;
  logic [31:0]     pc_current;
  logic            proc_start;
  logic [PIDW-1:0] proc_start_id;
  logic [31:0]     proc_start_addr;
  logic            proc_end;
  logic [31:0]     pc_restore;
  logic            pc_load;
  logic            inProgram;
  logic [PIDW-1:0] proc_id;
  logic            busy;

  modport master (
    output ContextChangeBack, pc_current, proc_start, proc_start_id,
           proc_start_addr, proc_end,
    input  pc_restore, pc_load, inProgram, proc_id, busy
  );

  modport slave (
    input  ContextChangeBack, pc_current, proc_start, proc_start_id,
           proc_start_addr, proc_end,
    output pc_restore, pc_load, inProgram, proc_id, busy
  );
endinterface

// File: rtl/context_switch_ctrl_rr_pick.sv
// Round-robin search: first valid slot after cur_id, wrapping back to cur_id.
module rr_pick
  import cs_pkg::*;
#(
  parameter int NPROC = CS_NPROC,
  parameter int PIDW  = CS_PIDW
) (
  input  logic [NPROC-1:0] valid,
  input  logic [PIDW-1:0]  cur_id,
  output logic [PIDW-1:0]  nxt_id,
  output logic             any_valid
);

  logic [PIDW-1:0] idx;

  // Scan from the farthest offset down so the nearest valid slot wins;
  // offset NPROC wraps to cur_id itself.
  always_comb begin
    nxt_id    = cur_id;
    any_valid = |valid;
    idx       = '0;
    for (int i = NPROC; i >= 1; i--) begin
      idx = cur_id + PIDW'(i);
      if (valid[idx]) nxt_id = idx;
    end
  end

endmodule

// File: rtl/context_switch_ctrl.sv
// Context-switch controller: saves/restores per-process PCs in round-robin order.
module context_switch_ctrl
  import cs_pkg::*;
#(
  parameter int NPROC = CS_NPROC,
  parameter int PIDW  = CS_PIDW
) (
  input  logic                  CLK,
  input  logic                  reset,
  context_switch_ctrl_if.slave  bus
);

  cs_state_t        state, state_nxt;
  logic             ccb_q;
  logic             rise;
  logic [31:0]      tbl [NPROC];
  logic [NPROC-1:0] valid;
  logic [PIDW-1:0]  cur_id;
  logic [PIDW-1:0]  pick_id;
  logic             any_valid;

  // Edges are only acted on in RUN, which cannot be reached within one cycle
  // of reset, so a level already high at release never looks like an edge.
  assign rise = bus.ContextChangeBack & ~ccb_q;

  rr_pick #(.NPROC(NPROC), .PIDW(PIDW)) u_pick (
    .valid     (valid),
    .cur_id    (cur_id),
    .nxt_id    (pick_id),
    .any_valid (any_valid)
  );

  // State register, edge-detect register and running slot id.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= S_EMPTY;
      ccb_q  <= 1'b0;
      cur_id <= '0;
    end else begin
      state <= state_nxt;
      ccb_q <= bus.ContextChangeBack;
      if (state == S_SELECT && any_valid) cur_id <= pick_id;
    end
  end

  // Next-state logic; proc_end beats a same-cycle switch request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:   if (bus.proc_start || (|valid)) state_nxt = S_SELECT;
      S_RUN: begin
        if (bus.proc_end) state_nxt = S_SELECT;
        else if (rise)    state_nxt = S_SAVE;
      end
      S_SAVE:    state_nxt = S_SELECT;
      S_SELECT:  state_nxt = any_valid ? S_RESTORE : S_EMPTY;
      S_RESTORE: state_nxt = S_RUN;
      default:   state_nxt = S_EMPTY;
    endcase
  end

  // Process table; later assignments win, so proc_start overrides a save
  // or a clear aimed at the same slot.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < NPROC; i++) tbl[i] <= '0;
    end else begin
      if (state == S_RUN && bus.proc_end) valid[cur_id] <= 1'b0;
      if (state == S_SAVE)                tbl[cur_id]   <= bus.pc_current;
      if (bus.proc_start) begin
        tbl[bus.proc_start_id]   <= bus.proc_start_addr;
        valid[bus.proc_start_id] <= 1'b1;
      end
    end
  end

  assign bus.pc_load    = (state == S_RESTORE);
  assign bus.pc_restore = (state == S_RESTORE) ? tbl[cur_id] : '0;
  assign bus.inProgram  = (state == S_RUN);
  assign bus.proc_id    = cur_id;
  assign bus.busy       = (state == S_SAVE) || (state == S_SELECT) ||
                          (state == S_RESTORE);

endmodule
